ctrl_sync_stretch: RTL

CTRL_SYNC_STRETCH -- requirements
Module: ctrl_sync_stretch

---
 rtl/ctrl_sync_stretch.sv | 129 ++++++++++++
 1 files changed

// File: rtl/ctrl_sync_stretch.sv
// Per-channel CDC synchroniser with edge detection and pulse stretching into bclk.
// Optional overrun detection is compiled in with CTRL_SYNC_OVR_EN.
module ctrl_sync_stretch #(
  parameter int unsigned CH          = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned STRETCH     = 3,
  parameter int unsigned EDGE_MODE   = 0
) (
  input  logic          bclk,
  input  logic          rst,
  input  logic [CH-1:0] adat,
  output logic [CH-1:0] bdat,
  output logic [CH-1:0] blvl,
  output logic          bany,
  input  logic [CH-1:0] ovr_clr,
  output logic [CH-1:0] ovr
);

  localparam int unsigned CW   = $clog2(STRETCH + 1);
  localparam int unsigned FILL = SYNC_STAGES + 1;
  localparam int unsigned FW   = $clog2(FILL + 1);

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_BOTH = 2'd2
  } edge_mode_e;

  localparam edge_mode_e MODE = edge_mode_e'(EDGE_MODE);

  logic [CH-1:0] sync [SYNC_STAGES];
  logic [CH-1:0] hist;
  logic [CH-1:0] last;
  logic [FW-1:0] fill;
  logic          armed;
  logic [CH-1:0] edge_raw;
  logic [CH-1:0] edge_det;
  logic [CH-1:0] busy;
  logic [CH-1:0] bdat_nxt;
  logic [CW-1:0] cnt     [CH];
  logic [CW-1:0] cnt_nxt [CH];

  // Synchroniser chain, history flop and post-reset fill counter.
  always_ff @(posedge bclk) begin
    if (rst) begin
      for (int unsigned j = 0; j < SYNC_STAGES; j++) begin
        sync[j] <= '0;
      end
      hist <= '0;
      fill <= '0;
    end else begin
      sync[0] <= adat;
      for (int unsigned j = 1; j < SYNC_STAGES; j++) begin
        sync[j] <= sync[j-1];
      end
      hist <= last;
      if (!armed) begin
        fill <= fill + 1'b1;
      end
    end
  end

  assign last  = sync[SYNC_STAGES-1];
  assign blvl  = last;
  assign armed = (fill == FW'(FILL));

  always_comb begin
    edge_raw = '0;
    case (MODE)
      EDGE_RISE: edge_raw = last & ~hist;
      EDGE_FALL: edge_raw = ~last & hist;
      default:   edge_raw = last ^ hist;
    endcase
  end

  // Edges are ignored until the chain has refilled with post-reset samples.
  assign edge_det = armed ? edge_raw : '0;

  always_comb begin
    for (int unsigned i = 0; i < CH; i++) begin
      busy[i]     = (cnt[i] != '0);
      cnt_nxt[i]  = cnt[i];
      if (edge_det[i]) begin
        cnt_nxt[i] = CW'(STRETCH);
      end else if (busy[i]) begin
        cnt_nxt[i] = cnt[i] - 1'b1;
      end
      bdat_nxt[i] = (cnt_nxt[i] != '0);
    end
  end

  // bdat is registered from the next counter value so it tracks the counter exactly.
  always_ff @(posedge bclk) begin
    if (rst) begin
      for (int unsigned i = 0; i < CH; i++) begin
        cnt[i] <= '0;
      end
      bdat <= '0;
      bany <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < CH; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
      bdat <= bdat_nxt;
      bany <= |bdat;
    end
  end

`ifdef CTRL_SYNC_OVR_EN
  logic [CH-1:0] retrig;

  assign retrig = edge_det & busy;

  // A retrigger wins over a clear arriving in the same cycle.
  always_ff @(posedge bclk) begin
    if (rst) begin
      ovr <= '0;
    end else begin
      ovr <= retrig | (ovr & ~ovr_clr);
    end
  end
`else
  logic unused_ovr_clr;

  assign unused_ovr_clr = ^ovr_clr;
  assign ovr            = '0;
`endif

endmodule
